// File: rtl/tff_toggle_decoder_if.sv
// Event handshake between the toggle decoder and its consumer.
// The decoder drives valid/dir; the consumer drives ready.
interface tff_toggle_decoder_if;
    logic evt_valid;
    logic evt_ready;
    logic evt_dir;

    modport master (
        output evt_valid,
        output evt_dir,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_dir,
        output evt_ready
    );
endinterface

// File: rtl/tff_toggle_decoder.sv
// Turns each flip of a T flip-flop level back into a one-cycle pulse,
// with glitch filtering, a toggle counter and a one-deep event queue.
module tff_toggle_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic             clr_ovr,
    output logic             level,
    output logic             pulse,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             overrun,
    tff_toggle_decoder_if.master evt
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        STABLE = 1'b0,
        FILTER = 1'b1
    } state_e;

    logic t_s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign t_s = t_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= t_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign t_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    stab_q, stab_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             dir_q, dir_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             consume;
    logic             ovr_set;

    // A toggle is accepted once t_s has differed from level for
    // STABLE_CYCLES consecutive samples; any agreeing sample restarts.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        accept  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (t_s != level_q) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = FILTER;
                        stab_d  = CW'(1);
                    end
                end
            end
            FILTER: begin
                if (t_s == level_q) begin
                    state_d = STABLE;
                    stab_d  = '0;
                end else if (stab_q == LAST) begin
                    accept  = 1'b1;
                    state_d = STABLE;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE;
                stab_d  = '0;
            end
        endcase
    end

    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        dir_d   = dir_q;
        ovr_set = 1'b0;
        consume = valid_q & evt.evt_ready;
        if (accept) begin
            level_d = ~level_q;
            pulse_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (!valid_q || consume) begin
                valid_d = 1'b1;
                dir_d   = ~level_q;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
        // A new overrun beats a simultaneous clear.
        ovr_d = (ovr_q & ~clr_ovr) | ovr_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE;
            stab_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            ovr_q   <= ovr_d;
        end
    end

    assign level         = level_q;
    assign pulse         = pulse_q;
    assign toggle_cnt    = cnt_q;
    assign overrun       = ovr_q;
    assign evt.evt_valid = valid_q;
    assign evt.evt_dir   = dir_q;

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// Randomised and directed bench for tff_toggle_decoder against a
// run-length reference model of the toggle filter and event queue.
module tb_tff_toggle_decoder;

    localparam int SYNC = 2;
    localparam int SC   = 4;

    logic       clk;
    logic       rst;
    logic       t_in;
    logic       clr_ovr;
    logic       level;
    logic       pulse;
    logic [7:0] toggle_cnt;
    logic       overrun;

    logic       t2;
    logic       clr2;
    logic       level2;
    logic       pulse2;
    logic [7:0] cnt2;
    logic       ovr2;

    tff_toggle_decoder_if ev ();
    tff_toggle_decoder_if ev2 ();

    tff_toggle_decoder #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(SC),
        .CNT_W        (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .t_in      (t_in),
        .clr_ovr   (clr_ovr),
        .level     (level),
        .pulse     (pulse),
        .toggle_cnt(toggle_cnt),
        .overrun   (overrun),
        .evt       (ev)
    );

    tff_toggle_decoder #(
        .SYNC_STAGES  (0),
        .STABLE_CYCLES(1),
        .CNT_W        (8)
    ) u_fast (
        .clk       (clk),
        .rst       (rst),
        .t_in      (t2),
        .clr_ovr   (clr2),
        .level     (level2),
        .pulse     (pulse2),
        .toggle_cnt(cnt2),
        .overrun   (ovr2),
        .evt       (ev2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int n_pulse = 0;

    int         m_run;
    logic       m_level, m_pulse, m_valid, m_dir, m_ovr;
    logic [7:0] m_cnt;
    logic       m_hist [SYNC];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Accept = STABLE_CYCLES consecutive synchronized samples unlike level.
    task automatic model_step();
        logic ts, acc, cons, set;
        ts = m_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = t_in;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
            m_run = 0; m_level = 0; m_pulse = 0; m_valid = 0;
            m_dir = 0; m_ovr = 0; m_cnt = 0;
            return;
        end
        acc = 1'b0;
        set = 1'b0;
        m_pulse = 1'b0;
        m_run = (ts != m_level) ? m_run + 1 : 0;
        if (m_run == SC) begin
            acc = 1'b1;
            m_run = 0;
        end
        cons = m_valid & ev.evt_ready;
        if (acc) begin
            m_level = ~m_level;
            m_pulse = 1'b1;
            m_cnt = m_cnt + 8'd1;
            if (!m_valid || cons) begin
                m_valid = 1'b1;
                m_dir = m_level;
            end else begin
                set = 1'b1;
            end
        end else if (cons) begin
            m_valid = 1'b0;
        end
        m_ovr = (m_ovr & ~clr_ovr) | set;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("level", level, m_level);
        chk("pulse", pulse, m_pulse);
        chk("toggle_cnt", toggle_cnt, m_cnt);
        chk("evt_valid", ev.evt_valid, m_valid);
        chk("evt_dir", ev.evt_dir, m_dir);
        chk("overrun", overrun, m_ovr);
        if (pulse === 1'b1) n_pulse++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        t_in = 1'b0;
        ev.evt_ready = 1'b0;
        clr_ovr = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        t_in = 1'b1;
        clr_ovr = 1'b0;
        ev.evt_ready = 1'b0;
        t2 = 1'b0;
        clr2 = 1'b0;
        ev2.evt_ready = 1'b1;
        m_run = 0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;

        // Reset with t_in high
        repeat (2) begin
            cycle();
            chk("rst_outs", {level, pulse, toggle_cnt, overrun,
                ev.evt_valid, ev.evt_dir}, 32'd0);
        end

        // Clean toggle: pulse exactly after E0+5
        do_reset();
        t_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("t2_pulse_time", pulse, (i == 5) ? 32'd1 : 32'd0);
        end
        chk("t2_level", level, 1);
        chk("t2_cnt", toggle_cnt, 1);
        chk("t2_valid", ev.evt_valid, 1);
        chk("t2_dir", ev.evt_dir, 1);
        ev.evt_ready = 1'b1;
        cycle();
        ev.evt_ready = 1'b0;
        chk("t2_consumed", ev.evt_valid, 0);

        // Glitch of three cycles
        do_reset();
        p0 = n_pulse;
        t_in = 1'b1;
        repeat (3) cycle();
        t_in = 1'b0;
        repeat (10) cycle();
        chk("t3_pulses", n_pulse - p0, 0);
        chk("t3_level", level, 0);
        chk("t3_cnt", toggle_cnt, 0);

        // Overrun, then clear
        do_reset();
        t_in = 1'b1;
        repeat (6) cycle();
        t_in = 1'b0;
        repeat (6) cycle();
        chk("t4_dir", ev.evt_dir, 1);
        chk("t4_ovr", overrun, 1);
        chk("t4_cnt", toggle_cnt, 2);
        chk("t4_level", level, 0);
        clr_ovr = 1'b1;
        cycle();
        clr_ovr = 1'b0;
        chk("t4_ovr_clr", overrun, 0);

        // Accept and consume on the same edge
        do_reset();
        t_in = 1'b1;
        repeat (6) cycle();
        t_in = 1'b0;
        repeat (5) cycle();
        ev.evt_ready = 1'b1;
        cycle();
        ev.evt_ready = 1'b0;
        chk("t4b_valid", ev.evt_valid, 1);
        chk("t4b_dir", ev.evt_dir, 0);
        chk("t4b_ovr", overrun, 0);

        // Counter wrap
        do_reset();
        ev.evt_ready = 1'b1;
        p0 = n_pulse;
        for (int k = 0; k < 256; k++) begin
            t_in = ~t_in;
            repeat (6) cycle();
            if (k == 254) chk("t5_cnt_ff", toggle_cnt, 8'hff);
        end
        chk("t5_cnt_wrap", toggle_cnt, 0);
        chk("t5_pulses", n_pulse - p0, 256);
        ev.evt_ready = 1'b0;

        // Reset during FILTER
        do_reset();
        p0 = n_pulse;
        t_in = 1'b1;
        repeat (3) cycle();
        rst = 1'b1;
        t_in = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (8) cycle();
        chk("t6_pulses", n_pulse - p0, 0);
        chk("t6_level", level, 0);
        chk("t6_cnt", toggle_cnt, 0);

        // Bypass synchronizer, single-sample acceptance
        t2 = 1'b1;
        cycle();
        chk("t6b_pulse", pulse2, 1);
        chk("t6b_level", level2, 1);
        cycle();
        chk("t6b_pulse_off", pulse2, 0);
        t2 = 1'b0;
        cycle();
        chk("t6b_pulse2", pulse2, 1);
        chk("t6b_level2", level2, 0);
        chk("t6b_valid", ev2.evt_valid, 1);
        chk("t6b_dir", ev2.evt_dir, 0);
        chk("t6b_cnt", cnt2, 2);
        chk("t6b_ovr", ovr2, 0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) t_in = ~t_in;
            ev.evt_ready = ($urandom_range(0, 2) == 0);
            clr_ovr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
